// File: rtl/snake_color_mapper.sv
// snake_color_mapper: maps renderer tile codes to RGB through frame-shadowed colour registers.
// Optional food blink is enabled by defining SNAKE_FOOD_BLINK_EN.
module snake_color_mapper #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int CH_BITS            = 4,
    parameter int BLINK_FRAMES       = 30
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_bg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_body,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_head,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_food,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic                          pix_active,
    input  logic [1:0]                    pix_tile,
    output logic                          rgb_valid,
    output logic [3*CH_BITS-1:0]          rgb_out,
    output logic                          cfg_loaded
);

    localparam logic [23:0] BG_RST   = 24'h000000;
    localparam logic [23:0] BODY_RST = 24'h00FF00;
    localparam logic [23:0] HEAD_RST = 24'hFFFF00;
    localparam logic [23:0] FOOD_RST = 24'hFF0000;

    localparam logic [1:0] TILE_BG   = 2'd0;
    localparam logic [1:0] TILE_BODY = 2'd1;
    localparam logic [1:0] TILE_HEAD = 2'd2;
    localparam logic [1:0] TILE_FOOD = 2'd3;

    // Shadow colour registers, only touched on frame boundaries
    logic [23:0] bg_q, bg_d;
    logic [23:0] body_q, body_d;
    logic [23:0] head_q, head_d;
    logic [23:0] food_q, food_d;
    logic        cfg_loaded_q, cfg_loaded_d;

    // Stage 1 registers
    logic        s1_valid_q, s1_valid_d;
    logic        s1_active_q, s1_active_d;
    logic [1:0]  s1_tile_q, s1_tile_d;

    // Stage 2 (output) registers
    logic                 rgb_valid_q, rgb_valid_d;
    logic [3*CH_BITS-1:0] rgb_q, rgb_d;

    // High for food tiles that should render as background this frame
    logic        food_hide;
    logic [23:0] sel_color;

    // The top byte of each colour register carries no colour information
    logic [31:0] unused_cfg_hi;
    assign unused_cfg_hi = {cfg_bg[C_S_AXI_DATA_WIDTH-1 -: 8],
                            cfg_body[C_S_AXI_DATA_WIDTH-1 -: 8],
                            cfg_head[C_S_AXI_DATA_WIDTH-1 -: 8],
                            cfg_food[C_S_AXI_DATA_WIDTH-1 -: 8]};

`ifdef SNAKE_FOOD_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       blink_q, blink_d;

    // Frame counter and blink phase advance together with the shadow load
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Blink state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign food_hide = blink_q;
`else
    logic [7:0] unused_blink_frames;
    assign unused_blink_frames = 8'(BLINK_FRAMES);
    assign food_hide = 1'b0;
`endif

    // Capture all four colours atomically at the start of vertical blank
    always_comb begin
        bg_d         = bg_q;
        body_d       = body_q;
        head_d       = head_q;
        food_d       = food_q;
        cfg_loaded_d = frame_start;
        if (frame_start) begin
            bg_d   = cfg_bg[23:0];
            body_d = cfg_body[23:0];
            head_d = cfg_head[23:0];
            food_d = cfg_food[23:0];
        end
    end

    // Stage 1 simply registers the incoming beat
    always_comb begin
        s1_valid_d  = pix_valid;
        s1_active_d = pix_active;
        s1_tile_d   = pix_tile;
    end

    // Colour lookup uses the shadows as they stand before this edge
    always_comb begin
        sel_color = bg_q;
        unique case (s1_tile_q)
            TILE_BG:   sel_color = bg_q;
            TILE_BODY: sel_color = body_q;
            TILE_HEAD: sel_color = head_q;
            TILE_FOOD: sel_color = food_hide ? bg_q : food_q;
            default:   sel_color = bg_q;
        endcase
    end

    // Stage 2: truncate to channel MSBs, blank outside the visible area, hold when idle
    always_comb begin
        rgb_valid_d = s1_valid_q;
        rgb_d       = rgb_q;
        if (s1_valid_q) begin
            if (s1_active_q) begin
                rgb_d = {sel_color[23 -: CH_BITS],
                         sel_color[15 -: CH_BITS],
                         sel_color[7 -: CH_BITS]};
            end else begin
                rgb_d = '0;
            end
        end
    end

    // Shadow registers and load pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bg_q         <= BG_RST;
            body_q       <= BODY_RST;
            head_q       <= HEAD_RST;
            food_q       <= FOOD_RST;
            cfg_loaded_q <= 1'b0;
        end else begin
            bg_q         <= bg_d;
            body_q       <= body_d;
            head_q       <= head_d;
            food_q       <= food_d;
            cfg_loaded_q <= cfg_loaded_d;
        end
    end

    // Pipeline registers; reset drops any beat in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_active_q <= 1'b0;
            s1_tile_q   <= 2'd0;
            rgb_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_active_q <= s1_active_d;
            s1_tile_q   <= s1_tile_d;
            rgb_valid_q <= rgb_valid_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb_valid  = rgb_valid_q;
    assign rgb_out    = rgb_q;
    assign cfg_loaded = cfg_loaded_q;

endmodule

// File: tb/tb_snake_color_mapper.sv
// tb_snake_color_mapper: directed checks of the colour mapper.
// Define SNAKE_FOOD_BLINK_EN to exercise the blink build (BLINK_FRAMES=2).
module tb_snake_color_mapper;

    logic        clock;
    logic        reset;
    logic [31:0] cfg_bg;
    logic [31:0] cfg_body;
    logic [31:0] cfg_head;
    logic [31:0] cfg_food;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_active;
    logic [1:0]  pix_tile;
    logic        rgb_valid;
    logic [11:0] rgb_out;
    logic        cfg_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    snake_color_mapper #(
        .C_S_AXI_DATA_WIDTH(32),
        .CH_BITS(4),
        .BLINK_FRAMES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_bg(cfg_bg),
        .cfg_body(cfg_body),
        .cfg_head(cfg_head),
        .cfg_food(cfg_food),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .pix_active(pix_active),
        .pix_tile(pix_tile),
        .rgb_valid(rgb_valid),
        .rgb_out(rgb_out),
        .cfg_loaded(cfg_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic a, input logic [1:0] t);
        pix_valid  = v;
        pix_active = a;
        pix_tile   = t;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        frame_start = 1'b0;
        cfg_bg      = 32'h0000_0000;
        cfg_body    = 32'h0000_FF00;
        cfg_head    = 32'h00FF_FF00;
        cfg_food    = 32'h00FF_0000;
        drive(1'b0, 1'b0, 2'd0);
        tick;
        tick;
        n_checks++;
        if (rgb_valid !== 1'b0 || rgb_out !== 12'h000 || cfg_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b rgb=%h loaded=%b, want 0 000 0",
                     rgb_valid, rgb_out, cfg_loaded);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_default_colors;
        logic [11:0] exp_rgb [4];
        int nvalid;
        exp_rgb[0] = 12'h000;
        exp_rgb[1] = 12'h0F0;
        exp_rgb[2] = 12'hFF0;
        exp_rgb[3] = 12'hF00;
        nvalid = 0;
        for (int t = 0; t < 7; t++) begin
            if (t < 4) drive(1'b1, 1'b1, 2'(t));
            else       drive(1'b0, 1'b0, 2'd0);
            tick;
            if (rgb_valid === 1'b1) nvalid++;
            n_checks++;
            if (t >= 1 && t <= 4) begin
                if (rgb_valid !== 1'b1 || rgb_out !== exp_rgb[t-1]) begin
                    n_fail++;
                    $display("FAIL default_tile%0d: valid=%b rgb=%h, want 1 %h",
                             t - 1, rgb_valid, rgb_out, exp_rgb[t-1]);
                end
            end else if (rgb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL default_idle_t%0d: valid=%b, want 0", t, rgb_valid);
            end
        end
        n_checks++;
        if (nvalid != 4) begin
            n_fail++;
            $display("FAIL default_valid_count: got %0d, want 4", nvalid);
        end
    endtask

    task automatic test_midframe_write;
        cfg_head = 32'hAB12_CD34;
        drive(1'b1, 1'b1, 2'd2);
        tick;
        drive(1'b0, 1'b0, 2'd0);
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'hFF0) begin
            n_fail++;
            $display("FAIL head_before_load: valid=%b rgb=%h, want 1 ff0", rgb_valid, rgb_out);
        end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_checks++;
        if (cfg_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL load_pulse: loaded=%b, want 1", cfg_loaded);
        end
        tick;
        n_checks++;
        if (cfg_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pulse_end: loaded=%b, want 0", cfg_loaded);
        end
        drive(1'b1, 1'b1, 2'd2);
        tick;
        drive(1'b0, 1'b0, 2'd0);
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'h1C3) begin
            n_fail++;
            $display("FAIL head_after_load: valid=%b rgb=%h, want 1 1c3", rgb_valid, rgb_out);
        end
    endtask

    task automatic test_coincident_load;
        cfg_body = 32'h0000_00FF;
        drive(1'b1, 1'b1, 2'd1);
        tick;
        frame_start = 1'b1;
        drive(1'b1, 1'b1, 2'd1);
        tick;
        frame_start = 1'b0;
        drive(1'b0, 1'b0, 2'd0);
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'h0F0) begin
            n_fail++;
            $display("FAIL body_old_shadow: valid=%b rgb=%h, want 1 0f0", rgb_valid, rgb_out);
        end
        n_checks++;
        if (cfg_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL coincident_load_pulse: loaded=%b, want 1", cfg_loaded);
        end
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'h00F) begin
            n_fail++;
            $display("FAIL body_new_shadow: valid=%b rgb=%h, want 1 00f", rgb_valid, rgb_out);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        cfg_body    = 32'h0000_FF00;
        frame_start = 1'b1;
        tick;
        n_checks++;
        if (cfg_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_pulse: loaded=%b, want 1", cfg_loaded);
        end
        cfg_body = 32'h00FF_FFFF;
        tick;
        frame_start = 1'b0;
        n_checks++;
        if (cfg_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_pulse: loaded=%b, want 1", cfg_loaded);
        end
        drive(1'b1, 1'b1, 2'd1);
        tick;
        n_checks++;
        if (cfg_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse_end: loaded=%b, want 0", cfg_loaded);
        end
        drive(1'b0, 1'b0, 2'd0);
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'hFFF) begin
            n_fail++;
            $display("FAIL b2b_second_value: valid=%b rgb=%h, want 1 fff", rgb_valid, rgb_out);
        end
    endtask

    task automatic test_inactive_invalid;
        drive(1'b1, 1'b1, 2'd2);
        tick;
        drive(1'b0, 1'b1, 2'd3);
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'h1C3) begin
            n_fail++;
            $display("FAIL hold_setup: valid=%b rgb=%h, want 1 1c3", rgb_valid, rgb_out);
        end
        drive(1'b0, 1'b0, 2'd0);
        tick;
        n_checks++;
        if (rgb_valid !== 1'b0 || rgb_out !== 12'h1C3) begin
            n_fail++;
            $display("FAIL invalid_beat_hold: valid=%b rgb=%h, want 0 1c3", rgb_valid, rgb_out);
        end
        drive(1'b1, 1'b0, 2'd2);
        tick;
        drive(1'b0, 1'b0, 2'd0);
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'h000) begin
            n_fail++;
            $display("FAIL inactive_blank: valid=%b rgb=%h, want 1 000", rgb_valid, rgb_out);
        end
        tick;
    endtask

    task automatic test_reset_midflight;
        int stray;
        drive(1'b1, 1'b1, 2'd2);
        tick;
        drive(1'b1, 1'b1, 2'd1);
        tick;
        drive(1'b0, 1'b0, 2'd0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (rgb_valid !== 1'b0 || rgb_out !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b rgb=%h, want 0 000", rgb_valid, rgb_out);
        end
        tick;
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rgb_valid !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL reset_drop: %0d stray beats, want 0", stray);
        end
        drive(1'b1, 1'b1, 2'd2);
        tick;
        drive(1'b1, 1'b1, 2'd1);
        tick;
        drive(1'b0, 1'b0, 2'd0);
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'hFF0) begin
            n_fail++;
            $display("FAIL reset_head_default: valid=%b rgb=%h, want 1 ff0", rgb_valid, rgb_out);
        end
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'h0F0) begin
            n_fail++;
            $display("FAIL reset_body_default: valid=%b rgb=%h, want 1 0f0", rgb_valid, rgb_out);
        end
        tick;
    endtask

    task automatic test_food_blink;
        logic [11:0] exp_food [6];
`ifdef SNAKE_FOOD_BLINK_EN
        exp_food[0] = 12'hF00;
        exp_food[1] = 12'h123;
        exp_food[2] = 12'h123;
        exp_food[3] = 12'hF00;
        exp_food[4] = 12'hF00;
        exp_food[5] = 12'h123;
`else
        for (int i = 0; i < 6; i++) exp_food[i] = 12'hF00;
`endif
        cfg_bg = 32'h0010_2030;
        for (int f = 0; f < 6; f++) begin
            frame_start = 1'b1;
            tick;
            frame_start = 1'b0;
            drive(1'b1, 1'b1, 2'd3);
            tick;
            drive(1'b0, 1'b0, 2'd0);
            tick;
            n_checks++;
            if (rgb_valid !== 1'b1 || rgb_out !== exp_food[f]) begin
                n_fail++;
                $display("FAIL food_frame%0d: valid=%b rgb=%h, want 1 %h",
                         f + 1, rgb_valid, rgb_out, exp_food[f]);
            end
        end
        drive(1'b1, 1'b1, 2'd0);
        tick;
        drive(1'b0, 1'b0, 2'd0);
        tick;
        n_checks++;
        if (rgb_valid !== 1'b1 || rgb_out !== 12'h123) begin
            n_fail++;
            $display("FAIL bg_reloaded: valid=%b rgb=%h, want 1 123", rgb_valid, rgb_out);
        end
    endtask

    initial begin
        test_reset;
        test_default_colors;
        test_midframe_write;
        test_coincident_load;
        test_back_to_back;
        test_inactive_invalid;
        test_reset_midflight;
        test_food_blink;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
